matvec_ctrl: RTL
================

Name: matvec_ctrl

Overview:
- Streaming controller for the pipelined matrix-vector multiply datapath `matvec_mul`.
- Loads the R×C weight matrix row by row into a local weight bank and holds it stable while computing.
- Accepts x vectors and returns y vectors over valid/ready handshakes.
- Stalls the whole datapath through `cen` under output backpressure, and drains in-flight work before any weight reload.

Parameters:
- R, 8, matrix rows / output lanes
- C, 8, matrix columns / input lanes
- W_X, 8, signed x element width
- W_K, 8, signed weight element width
- Derived, not overridable: DEPTH=$clog2(C); W_Y=W_X+W_K+DEPTH; LAT=DEPTH+1 (4 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- k_valid  in  1  weight row beat valid
- k_ready  out  1  weight row beat accepted when high with k_valid
- k_row  in  C*W_K  one signed weight row; element c at bits [c*W_K +: W_K]
- x_valid  in  1  input vector valid
- x_ready  out  1  input vector accepted when high with x_valid
- x  in  C*W_X  signed input vector, packed like k_row
- y_valid  out  1  result valid
- y_ready  in  1  result consumed when high with y_valid
- y  out  R*W_Y  signed result, lane r at [r*W_Y +: W_Y]
- reload  in  1  level request to replace weights
- state  out  2  current FSM state (status)
- inflight  out  $clog2(LAT+1)  number of valid vectors inside the datapath

Behaviour:
- Reset (async assert, sync release) forces:
  - state=LOAD, row counter=0, weight bank all zero
  - valid shift register vld[LAT-1:0]=0
  - y_valid=0, x_ready=0, k_ready=1, inflight=0
- Datapath internal registers are not reset; their contents are masked by vld.
- FSM:
  - LOAD(0): k_ready=1, x_ready=0. Each k handshake writes k_row into bank row `row`, then row++. The handshake with row==R-1 writes the last row, clears row and goes to RUN. reload is ignored.
  - RUN(1): k_ready=0; x_ready=cen. On reload=1, go to DRAIN next cycle. An x handshake in the same cycle as reload is accepted and completes normally.
  - DRAIN(2): x_ready=0, k_ready=0. The pipeline keeps advancing per cen. When inflight==0, go to LOAD with row=0.
  - Encoding 3 is unused; if reached, go to LOAD.
- Stall: cen = !vld[LAT-1] | y_ready, combinational, driven to `matvec_mul` every cycle.
- When cen=1, on each edge: vld <= {vld[LAT-2:0], x_valid & x_ready}.
- When cen=0, vld, the datapath and y hold.
- y_valid = vld[LAT-1]; y = datapath output. Both stay stable while y_valid & !y_ready.
- Latency: an x accepted at edge N gives y_valid high after edge N+LAT with no stall. Throughput is 1 vector/cycle when y_ready is continuously high.
- Bubbles inside the pipeline are not compressed. A stall at the output freezes every stage.
- inflight = popcount(vld).
- Arithmetic:
  - y[r] = Σc k[r][c]·x[c], full precision, signed, W_Y bits, no saturation or overflow.
  - Results use the weight bank contents at the time x was accepted; the bank cannot change in RUN or DRAIN.
- Reset mid-operation discards in-flight vectors and any partially loaded weight rows. No y_valid is produced for them.

Decomposition:
- Package matvec_pkg holds:
  - the state_t enum {LOAD=2'd0, RUN=2'd1, DRAIN=2'd2}
  - localparam functions for DEPTH, W_Y and LAT from C, W_X, W_K
- One sub-module: the existing `matvec_mul` instance, fed by the weight bank and x.
- The controller's own RTL covers FSM, row counter, weight bank, vld shift register, cen and popcount (≈200 lines).

Test Plan:
- Load identity (k[r][c]=1 iff r==c), send x=1..8 with y_ready=1 → y=1..8 exactly 4 cycles after the handshake; x_ready stays 1.
- Weights all -128, x all -128 → every lane y=+131072 (8·16384); weights all 127, x=-128 → -130048.
- Back-to-back 10 vectors, y_ready=1 → 10 consecutive y_valid cycles, in order, zero gaps.
- Hold y_ready=0 for 5 cycles while y_valid=1 → y stable, x_ready=0, inflight constant; after release, remaining results emerge in order with no loss or duplicates.
- Assert reload with 3 vectors inflight → x_ready drops, 3 old-weight results delivered, state goes DRAIN→LOAD, k_ready=1; load new rows, then the next x uses the new weights.
- Pulse rstn low during LOAD at row 5 and during RUN with inflight=2 → y_valid never asserts for lost work, state=LOAD, row=0, bank zero (x after a reload of zeros gives y=0).

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and derived-size helpers for the matrix-vector controller
// and its pipelined multiply datapath.
package matvec_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    function automatic int calc_depth(input int c);
        return $clog2(c);
    endfunction

    function automatic int calc_wy(input int w_x, input int w_k, input int c);
        return w_x + w_k + calc_depth(c);
    endfunction

    function automatic int calc_lat(input int c);
        return calc_depth(c) + 1;
    endfunction

endpackage

// File: rtl/matvec_if.sv
// Weight-load, vector-in and result-out handshakes of matvec_ctrl.
interface matvec_if
    import matvec_pkg::*;
#(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8
) ();
    localparam int W_Y = calc_wy(W_X, W_K, C);

    logic               k_valid;
    logic               k_ready;
    logic [C*W_K-1:0]   k_row;
    logic               x_valid;
    logic               x_ready;
    logic [C*W_X-1:0]   x;
    logic               y_valid;
    logic               y_ready;
    logic [R*W_Y-1:0]   y;
    logic               reload;

    modport master (
        output k_valid, k_row, x_valid, x, y_ready, reload,
        input  k_ready, x_ready, y_valid, y
    );

    modport slave (
        input  k_valid, k_row, x_valid, x, y_ready, reload,
        output k_ready, x_ready, y_valid, y
    );

endinterface

// File: rtl/matvec_mul.sv
// Pipelined signed matrix-vector multiply: one product stage followed by a
// registered binary adder tree; every stage advances only when cen is high.
module matvec_mul
    import matvec_pkg::*;
#(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int DEPTH = calc_depth(C),
    localparam int W_Y   = calc_wy(W_X, W_K, C)
) (
    input  logic                   clk,
    input  logic                   cen,
    input  logic [R*C*W_K-1:0]     w,
    input  logic [C*W_X-1:0]       x,
    output logic [R*W_Y-1:0]       y
);
    localparam int N     = 1 << DEPTH;
    localparam int NODES = 2 * N - 1;

    logic signed [W_Y-1:0] prod_s [R][N];
    // Heap layout: node 0 is the root, leaves occupy N-1 .. 2N-2.
    logic signed [W_Y-1:0] node_r [R][NODES];

    function automatic logic signed [W_Y-1:0] mul_ext(
        input logic [W_K-1:0] k,
        input logic [W_X-1:0] xv
    );
        logic signed [W_Y-1:0] ke;
        logic signed [W_Y-1:0] xe;
        ke = $signed({{(W_Y-W_K){k[W_K-1]}}, k});
        xe = $signed({{(W_Y-W_X){xv[W_X-1]}}, xv});
        return ke * xe;
    endfunction

    // Lane products; columns beyond C pad the tree with zeros.
    always_comb begin
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < N; i++) begin
                if (i < C) begin
                    prod_s[r][i] = mul_ext(w[(r*C+i)*W_K +: W_K], x[i*W_X +: W_X]);
                end else begin
                    prod_s[r][i] = {W_Y{1'b0}};
                end
            end
        end
    end

    // Product and adder-tree registers, frozen as a whole when cen is low.
    always_ff @(posedge clk) begin
        if (cen) begin
            for (int r = 0; r < R; r++) begin
                for (int i = 0; i < N; i++) begin
                    node_r[r][N-1+i] <= prod_s[r][i];
                end
                for (int i = 0; i < N-1; i++) begin
                    node_r[r][i] <= node_r[r][2*i+1] + node_r[r][2*i+2];
                end
            end
        end
    end

    // Tree roots form the packed result.
    always_comb begin
        for (int r = 0; r < R; r++) begin
            y[r*W_Y +: W_Y] = node_r[r][0];
        end
    end

endmodule

// File: rtl/matvec_ctrl.sv
// Streaming controller: loads the weight bank row by row, feeds x vectors
// through matvec_mul, stalls on output backpressure and drains before reload.
module matvec_ctrl
    import matvec_pkg::*;
#(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int DEPTH = calc_depth(C),
    localparam int W_Y   = calc_wy(W_X, W_K, C),
    localparam int LAT   = calc_lat(C),
    localparam int IW    = $clog2(LAT + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    matvec_if.slave        bus,
    output logic [1:0]     state,
    output logic [IW-1:0]  inflight
);
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

    logic [1:0]           state_r;
    logic [RW-1:0]        row_r;
    logic [R*C*W_K-1:0]   bank_r;
    logic [LAT-1:0]       vld_r;
    logic                 cen_s;
    logic                 k_ready_s;
    logic                 x_ready_s;
    logic                 k_fire_s;
    logic                 x_fire_s;
    logic [IW-1:0]        inflight_s;

    // The only stall source is a held result at the pipeline exit.
    assign cen_s = ~vld_r[LAT-1] | bus.y_ready;

    // Handshake readiness per state.
    always_comb begin
        k_ready_s = 1'b0;
        x_ready_s = 1'b0;
        case (state_r)
            ST_LOAD:  k_ready_s = 1'b1;
            ST_RUN:   x_ready_s = cen_s;
            ST_DRAIN: x_ready_s = 1'b0;
            default:  k_ready_s = 1'b0;
        endcase
    end

    assign k_fire_s = bus.k_valid & k_ready_s;
    assign x_fire_s = bus.x_valid & x_ready_s;

    // Control FSM and row counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_LOAD;
            row_r   <= {RW{1'b0}};
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (k_fire_s) begin
                        if (row_r == ROW_LAST) begin
                            row_r   <= {RW{1'b0}};
                            state_r <= ST_RUN;
                        end else begin
                            row_r <= row_r + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.reload) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_s == {IW{1'b0}}) begin
                        state_r <= ST_LOAD;
                        row_r   <= {RW{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                    row_r   <= {RW{1'b0}};
                end
            endcase
        end
    end

    // Weight bank; writable only while loading, so it is stable for in-flight work.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_r <= {(R*C*W_K){1'b0}};
        end else if (state_r == ST_LOAD && k_fire_s) begin
            bank_r[row_r*(C*W_K) +: C*W_K] <= bus.k_row;
        end
    end

    // Valid shift register tracks which datapath stages hold real vectors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_r <= {LAT{1'b0}};
        end else if (cen_s) begin
            vld_r <= {vld_r[LAT-2:0], x_fire_s};
        end
    end

    // Occupancy count.
    always_comb begin
        inflight_s = {IW{1'b0}};
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + IW'(vld_r[i]);
        end
    end

    matvec_mul #(
        .R   (R),
        .C   (C),
        .W_X (W_X),
        .W_K (W_K)
    ) u_mul (
        .clk (clk),
        .cen (cen_s),
        .w   (bank_r),
        .x   (bus.x),
        .y   (bus.y)
    );

    assign bus.k_ready = k_ready_s;
    assign bus.x_ready = x_ready_s;
    assign bus.y_valid = vld_r[LAT-1];
    assign state       = state_r;
    assign inflight    = inflight_s;

endmodule
